// File: rtl/ulpi_pkg.sv
// Shared ULPI register-port definitions: bus widths, arbiter state encoding and
// the PHY register addresses used by the on-chip requesters.
package ulpi_pkg;

  localparam int ULPI_ADDR_W = 6;
  localparam int ULPI_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RETRY = 2'd3
  } arb_state_e;

  localparam logic [ULPI_ADDR_W-1:0] FUN_CTRL = 6'h04;
  localparam logic [ULPI_ADDR_W-1:0] IFC_CTRL = 6'h07;
  localparam logic [ULPI_ADDR_W-1:0] OTG_CTRL = 6'h0A;
  localparam logic [ULPI_ADDR_W-1:0] SCRATCH  = 6'h16;

endpackage

// File: rtl/ulpi_reg_arbiter_if.sv
// Requester-side and ULPI-core-side signals of the register-port arbiter.
// master = the arbiter, slave = requesters plus ULPI core.
interface ulpi_reg_arbiter_if
  import ulpi_pkg::*;
#(
  parameter int NUM_REQ = 3
);

  logic [NUM_REQ-1:0]             REQ_EN;
  logic [NUM_REQ-1:0]             REQ_RW;
  logic [ULPI_ADDR_W*NUM_REQ-1:0] REQ_ADDR;
  logic [ULPI_DATA_W*NUM_REQ-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]             REQ_DONE;
  logic [NUM_REQ-1:0]             REQ_FAIL;
  logic [ULPI_DATA_W-1:0]         REQ_RDATA;
  logic                           REQ_BUSY;

  logic                           READY;
  logic                           REG_EN;
  logic                           REG_RW;
  logic [ULPI_ADDR_W-1:0]         REG_ADDR;
  logic [ULPI_DATA_W-1:0]         REG_DATA_I;
  logic [ULPI_DATA_W-1:0]         REG_DATA_O;
  logic                           REG_DONE;
  logic                           REG_FAIL;

  logic [15:0]                    STAT_RETRIES;
  logic [15:0]                    STAT_FAILS;

  modport master (
    input  REQ_EN, REQ_RW, REQ_ADDR, REQ_DATA,
    output REQ_DONE, REQ_FAIL, REQ_RDATA, REQ_BUSY,
    input  READY, REG_DATA_O, REG_DONE, REG_FAIL,
    output REG_EN, REG_RW, REG_ADDR, REG_DATA_I,
    output STAT_RETRIES, STAT_FAILS
  );

  modport slave (
    output REQ_EN, REQ_RW, REQ_ADDR, REQ_DATA,
    input  REQ_DONE, REQ_FAIL, REQ_RDATA, REQ_BUSY,
    output READY, REG_DATA_O, REG_DONE, REG_FAIL,
    input  REG_EN, REG_RW, REG_ADDR, REG_DATA_I,
    input  STAT_RETRIES, STAT_FAILS
  );

endinterface

// File: rtl/ulpi_rr_arbiter.sv
// Combinational round-robin grant: first set request at or after ptr, wrapping.
// Produces a one-hot grant, its index and a valid flag.
module ulpi_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  function automatic int wrap_idx(input int k);
    return (k >= NUM_REQ) ? k - NUM_REQ : k;
  endfunction

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_vld && req[wrap_idx(int'(ptr) + i)]) begin
        gnt_vld                          = 1'b1;
        gnt_oh[wrap_idx(int'(ptr) + i)]  = 1'b1;
        gnt_idx                          = IDX_W'(wrap_idx(int'(ptr) + i));
      end
    end
  end

endmodule

// File: rtl/ulpi_reg_arbiter.sv
// Round-robin sharing of the ULPI register port with retry and timeout.
// Define ULPI_REG_ARB_STATS_EN to build the saturating retry/failure counters.
module ulpi_reg_arbiter
  import ulpi_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input logic                CLK_60M,
  input logic                NRST_A_USB,
  ulpi_reg_arbiter_if.master bus
);

  localparam int         IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int         RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + IDX_W'(1);
  endfunction

  arb_state_e             state;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       own_idx;
  logic [7:0]             tmo_cnt;
  logic [RETRY_W-1:0]     retry_cnt;

  logic [NUM_REQ-1:0]     gnt_oh;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   gnt_vld;

  logic                   sel_rw;
  logic [ULPI_ADDR_W-1:0] sel_addr;
  logic [ULPI_DATA_W-1:0] sel_data;

  logic                   reg_en;
  logic                   reg_rw;
  logic [ULPI_ADDR_W-1:0] reg_addr;
  logic [ULPI_DATA_W-1:0] reg_wdata;
  logic                   req_busy;
  logic [NUM_REQ-1:0]     req_done_p1;
  logic [NUM_REQ-1:0]     req_fail_p1;
  logic [ULPI_DATA_W-1:0] rdata_p1;

  logic                   wait_abort;
  logic                   retry_ok;

  ulpi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req     (bus.REQ_EN),
    .ptr     (ptr),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    sel_rw   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        sel_rw   = bus.REQ_RW[i];
        sel_addr = bus.REQ_ADDR[i*ULPI_ADDR_W +: ULPI_ADDR_W];
        sel_data = bus.REQ_DATA[i*ULPI_DATA_W +: ULPI_DATA_W];
      end
    end
  end

  // REG_FAIL outranks a simultaneous REG_DONE; a timeout is treated like a fail.
  assign wait_abort = (state == ST_WAIT) && (bus.REG_FAIL || (tmo_cnt == TMO_LIMIT));
  assign retry_ok   = int'(retry_cnt) < MAX_RETRY;

  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      own_idx     <= '0;
      tmo_cnt     <= '0;
      retry_cnt   <= '0;
      reg_en      <= 1'b0;
      reg_rw      <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      req_busy    <= 1'b0;
      req_done_p1 <= '0;
      req_fail_p1 <= '0;
      rdata_p1    <= '0;
    end else begin
      reg_en      <= 1'b0;
      req_done_p1 <= '0;
      req_fail_p1 <= '0;
      case (state)
        ST_IDLE: begin
          if (bus.READY && gnt_vld) begin
            own_idx   <= gnt_idx;
            reg_rw    <= sel_rw;
            reg_addr  <= sel_addr;
            reg_wdata <= sel_data;
            retry_cnt <= '0;
            req_busy  <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          reg_en  <= 1'b1;
          tmo_cnt <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_abort) begin
            if (retry_ok) begin
              retry_cnt <= retry_cnt + RETRY_W'(1);
              state     <= ST_RETRY;
            end else begin
              req_fail_p1[own_idx] <= 1'b1;
              ptr                  <= next_idx(own_idx);
              req_busy             <= 1'b0;
              state                <= ST_IDLE;
            end
          end else if (bus.REG_DONE) begin
            req_done_p1[own_idx] <= 1'b1;
            if (!reg_rw) rdata_p1 <= bus.REG_DATA_O;
            ptr      <= next_idx(own_idx);
            req_busy <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        ST_RETRY: begin
          if (bus.READY) state <= ST_ISSUE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.REG_EN     = reg_en;
  assign bus.REG_RW     = reg_rw;
  assign bus.REG_ADDR   = reg_addr;
  assign bus.REG_DATA_I = reg_wdata;
  assign bus.REQ_BUSY   = req_busy;
  assign bus.REQ_DONE   = req_done_p1;
  assign bus.REQ_FAIL   = req_fail_p1;
  assign bus.REQ_RDATA  = rdata_p1;

`ifdef ULPI_REG_ARB_STATS_EN
  logic [15:0] stat_retries;
  logic [15:0] stat_fails;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      stat_retries <= '0;
      stat_fails   <= '0;
    end else begin
      if (wait_abort && retry_ok)  stat_retries <= sat_inc16(stat_retries);
      if (wait_abort && !retry_ok) stat_fails   <= sat_inc16(stat_fails);
    end
  end

  assign bus.STAT_RETRIES = stat_retries;
  assign bus.STAT_FAILS   = stat_fails;
`else
  assign bus.STAT_RETRIES = '0;
  assign bus.STAT_FAILS   = '0;
`endif

endmodule

// File: doc/ulpi_reg_arbiter.md
Name: ulpi_reg_arbiter

Overview:
Shares the single ULPI register-access port (REG_EN/REG_RW/REG_ADDR/REG_DATA_I in; REG_DONE/REG_FAIL/REG_DATA_O back) between NUM_REQ on-chip requesters, for example the PHY init sequencer, the audio-class control logic and a debug bridge.
- Arbitration is round-robin.
- It issues one REG_EN pulse per transaction, only while the ULPI READY output is high.
- It retries transactions aborted by REG_FAIL (DIR takeover) and times out hung transactions.
- It sits between the requesters and the ULPI core in the USB clock domain.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
MAX_RETRY, 3, re-issues allowed after REG_FAIL or timeout before reporting failure
TIMEOUT, 255, cycles allowed in WAIT before the transaction counts as failed (8-bit counter)

Ports:
CLK_60M  in  1  ULPI 60 MHz clock, single clock domain
NRST_A_USB  in  1  asynchronous active-low reset
REQ_EN  in  NUM_REQ  per-requester request, held until that requester's DONE/FAIL pulse
REQ_RW  in  NUM_REQ  1=write, 0=read
REQ_ADDR  in  6*NUM_REQ  register address, requester i at bits [6i+5:6i]
REQ_DATA  in  8*NUM_REQ  write data, requester i at bits [8i+7:8i]
REQ_DONE  out  NUM_REQ  one-cycle completion pulse to the owning requester
REQ_FAIL  out  NUM_REQ  one-cycle failure pulse (retries exhausted)
REQ_RDATA  out  8  read data, valid in the REQ_DONE cycle of a read, held until the next read completes
REQ_BUSY  out  1  a transaction is in flight
READY  in  1  ULPI core idle
REG_EN  out  1  one-cycle issue strobe to the ULPI core
REG_RW  out  1  latched direction
REG_ADDR  out  6  latched address
REG_DATA_I  out  8  latched write data
REG_DATA_O  in  8  read data from the ULPI core
REG_DONE  in  1  transaction completed
REG_FAIL  in  1  transaction aborted
STAT_RETRIES  out  16  total retries (optional feature)
STAT_FAILS  out  16  total reported failures (optional feature)

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE, pointer=0, all outputs 0, REG_EN deasserted immediately. An in-flight transaction is abandoned silently.
- States: IDLE, ISSUE, WAIT, RETRY.
- IDLE:
  - Transition: if READY=1 and |REQ_EN, grant g = first set REQ_EN at or after the pointer (wrapping). Latch that requester's RW/ADDR/DATA, set retry_cnt=0, go to ISSUE.
  - If READY=0, stay in IDLE.
- ISSUE:
  - Outputs: REG_EN=1 for exactly this cycle; timeout counter cleared.
  - Transition: go to WAIT.
- WAIT:
  - Outputs: the timeout counter increments every cycle.
  - On REG_DONE: pulse REQ_DONE[g] on the next cycle. For a read, REQ_RDATA ← REG_DATA_O registered alongside. Set pointer = g+1 mod NUM_REQ, go to IDLE.
  - On REG_FAIL, or when the counter reaches TIMEOUT:
    - If retry_cnt < MAX_RETRY: retry_cnt++, go to RETRY.
    - Otherwise: pulse REQ_FAIL[g], pointer = g+1, go to IDLE.
  - REG_DONE and REG_FAIL in the same cycle: REG_FAIL wins.
- RETRY:
  - Transition: wait for READY=1, then go to ISSUE with the same latched fields. Other requesters are not granted meanwhile.
- Latency: REQ_EN seen in IDLE with READY=1 → REG_EN 2 cycles later. REG_DONE → REQ_DONE 1 cycle later.
- REQ_BUSY=1 in ISSUE, WAIT and RETRY.
- REG_ADDR/REG_RW/REG_DATA_I stay stable from ISSUE until the return to IDLE.
- A requester that drops REQ_EN mid-transaction still receives its DONE/FAIL pulse.
- REQ_EN still high in the cycle after its DONE/FAIL pulse counts as a new request, at lower priority than the other requesters.
- REG_DONE or REG_FAIL arriving outside WAIT is ignored.

Optional Feature:
ULPI_REG_ARB_STATS_EN
- Defined:
  - STAT_RETRIES increments on every transition into RETRY.
  - STAT_FAILS increments on every REQ_FAIL pulse.
  - Both are 16-bit, saturate at 0xFFFF and are cleared by reset.
- Undefined: both ports are tied to 0 and no counter logic is generated.

Decomposition:
- Package ulpi_pkg: ULPI_ADDR_W=6 and ULPI_DATA_W=8; arbiter state encoding; ULPI register address constants (FUN_CTRL=6'h04, IFC_CTRL=6'h07, OTG_CTRL=6'h0A, SCRATCH=6'h16).
- Sub-module ulpi_rr_arbiter: combinational round-robin grant from request vector and pointer, producing a one-hot grant plus an index.

Test Plan:
1. Single write: req0 writes 0x16←0x5A, READY=1, REG_DONE 3 cycles after REG_EN → REG_EN pulses once with ADDR=0x16, DATA=0x5A, RW=1; REQ_DONE[0] follows one cycle after REG_DONE; REQ_FAIL=0.
2. Round-robin: req0, req1 and req2 all held high with immediate REG_DONE → grants in order 0,1,2,0; each REQ_DONE[i] is a single pulse.
3. Retry: req1 reads 0x0A; REG_FAIL on the first two attempts, then REG_DONE with REG_DATA_O=0xC3 → three REG_EN pulses; REQ_RDATA=0xC3 in the REQ_DONE[1] cycle; STAT_RETRIES=2 with the macro defined.
4. Exhaustion/timeout: no REG_DONE ever → MAX_RETRY+1=4 issues spaced TIMEOUT cycles apart, then REQ_FAIL[0]; STAT_FAILS=1 with the macro defined.
5. READY gating and reset: READY=0 with REQ_EN=1 → no REG_EN; assert NRST_A_USB low during WAIT → REG_EN, REQ_BUSY and all pulse outputs are 0 immediately; after release, state is IDLE and the pointer is 0.
